bof_interval_table: RTL and testbench
=====================================

// Module: bof_interval_table
// PURPOSE
// Interval store fed by the buffer-overflow protection unit: records closed byte-address
// ranges [first,last] flagged as overflowed writes and answers same-cycle membership
// queries for load addresses. Circular FIFO of DEPTH small intervals plus one sticky
// slot for large ("big") intervals that small writes never evict. Pure storage/lookup;
// crash policy stays upstream.
// PARAMETERS
// AW     32  address width (bits) of stored bounds and lookup address
// DEPTH  8   small-interval entries; power of two, >= 2
// PORTS
// clk_i          in   1             clock
// rst_ni         in   1             asynchronous active-low reset
// clear_i        in   1             synchronous flush of all entries and counters
// wr_en_i        in   1             write request, one interval per cycle
// wr_first_i     in   AW            interval lowest byte address
// wr_last_i      in   AW            interval highest byte address (inclusive)
// wr_big_i       in   1             interval goes to sticky slot instead of FIFO
// find_addr_i    in   AW            lookup address
// hit_o          out  1             find_addr_i inside any valid interval (comb.)
// hit_first_o    out  1             find_addr_i equals first of a hit interval (comb.)
// hit_sticky_o   out  1             hit came from sticky slot (comb.)
// count_o        out  $clog2(DEPTH)+1  valid FIFO entries (registered)
// full_o         out  1             count_o == DEPTH (registered)
// overwrite_o    out  1             one-cycle pulse: last write evicted oldest entry
// drop_o         out  1             one-cycle pulse: last write rejected (malformed)
// BEHAVIOUR
// - Reset: all valid bits 0, wr_ptr 0, count 0, sticky invalid; every output 0.
// - Entry i valid & first_i <= addr <= last_i (unsigned, inclusive both ends) -> hit.
//   hit_first_o set if any hit entry has first_i == addr. OR-reduced, no priority.
// - Lookup is combinational on current (registered) contents; a write in cycle N is
//   visible to lookups from cycle N+1. Same-cycle write does not affect hit_o.
// - Write accept (wr_en_i, !clear_i): wr_last_i < wr_first_i -> rejected, drop_o=1 next
//   cycle, no state change. Otherwise:
//   * wr_big_i=1: sticky slot <= {first,last}, valid=1; FIFO untouched; replaces prior.
//   * wr_big_i=0, exact duplicate of a valid FIFO entry (first and last equal): no
//     allocation, pointers/count unchanged, no pulse.
//   * else store at wr_ptr, wr_ptr <= wr_ptr+1 mod DEPTH (wraps DEPTH-1 -> 0);
//     count < DEPTH: count+1; count == DEPTH: oldest overwritten, count stays,
//     overwrite_o=1 next cycle.
// - clear_i: all valid bits, sticky, wr_ptr, count -> 0 next cycle; clear wins over a
//   simultaneous wr_en_i (write dropped silently, no drop_o).
// - overwrite_o/drop_o are 1-cycle pulses registered from the accept cycle, else 0.
// - Async reset mid-operation: state returns to reset values immediately; no partial
//   entry survives.
// - No arithmetic on bounds beyond compares; no overflow at AW boundary (last may be
//   2^AW-1).
// TESTING
// 1 Reset, find_addr=0x1000 -> hit_o=0, count_o=0, full_o=0.
// 2 Write [0x1000,0x1010]; same cycle find 0x1008 -> hit_o=0; next cycle 0x1000 ->
//   hit_o=1,hit_first_o=1; 0x1010 -> hit_o=1,hit_first_o=0; 0x1011 -> hit_o=0.
// 3 Write DEPTH+1 distinct intervals [0x100*k,0x100*k+0xF], k=1..9 -> full_o=1 after 8th,
//   overwrite_o pulse after 9th, 0x100 misses, 0x900 hits, count_o=8.
// 4 Write big [0x2000,0x2400] then 8 small writes -> 0x2200 still hits, hit_sticky_o=1.
// 5 Write [0x50,0x40] -> drop_o pulse, count_o unchanged; duplicate write -> count same.
// 6 wr_en_i with clear_i same cycle -> next cycle count_o=0, no hits, drop_o=0.

Source files
------------

// File: rtl/bof_interval_table_if.sv
// bof_interval_table_if: write, clear and lookup bundle for the overflow interval table.
// The _i/_o suffixes name the direction as seen from the table (slave side).
interface bof_interval_table_if #(
    parameter int AW = 32,
    parameter int DEPTH = 8
);
    logic                   clear_i;
    logic                   wr_en_i;
    logic [AW-1:0]          wr_first_i;
    logic [AW-1:0]          wr_last_i;
    logic                   wr_big_i;
    logic [AW-1:0]          find_addr_i;
    logic                   hit_o;
    logic                   hit_first_o;
    logic                   hit_sticky_o;
    logic [$clog2(DEPTH):0] count_o;
    logic                   full_o;
    logic                   overwrite_o;
    logic                   drop_o;
    modport slave (
        input  clear_i, wr_en_i, wr_first_i, wr_last_i, wr_big_i, find_addr_i,
        output hit_o, hit_first_o, hit_sticky_o, count_o, full_o, overwrite_o, drop_o
    );
    modport master (
        output clear_i, wr_en_i, wr_first_i, wr_last_i, wr_big_i, find_addr_i,
        input  hit_o, hit_first_o, hit_sticky_o, count_o, full_o, overwrite_o, drop_o
    );
endinterface

// File: rtl/bof_interval_table.sv
// bof_interval_table: circular FIFO of small overflowed byte ranges plus one sticky big range,
// with same-cycle inclusive membership lookup on the registered contents.
module bof_interval_table #(
    parameter int AW = 32,
    parameter int DEPTH = 8
) (
    input logic                 clk_i,
    input logic                 rst_ni,
    bof_interval_table_if.slave bus
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    logic [AW-1:0]    first_q [DEPTH];
    logic [AW-1:0]    first_d [DEPTH];
    logic [AW-1:0]    last_q  [DEPTH];
    logic [AW-1:0]    last_d  [DEPTH];
    logic [DEPTH-1:0] valid_q, valid_d;
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             full_q, full_d;
    logic [AW-1:0]    sticky_first_q, sticky_first_d;
    logic [AW-1:0]    sticky_last_q, sticky_last_d;
    logic             sticky_valid_q, sticky_valid_d;
    logic             overwrite_q, overwrite_d;
    logic             drop_q, drop_d;
    logic             fifo_hit, fifo_first, dup, sticky_hit;

    always_comb begin
        fifo_hit = 1'b0;
        fifo_first = 1'b0;
        dup = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (valid_q[i] && bus.find_addr_i >= first_q[i] && bus.find_addr_i <= last_q[i]) begin
                fifo_hit = 1'b1;
                if (bus.find_addr_i == first_q[i]) fifo_first = 1'b1;
            end
            if (valid_q[i] && first_q[i] == bus.wr_first_i && last_q[i] == bus.wr_last_i) dup = 1'b1;
        end
    end

    assign sticky_hit = sticky_valid_q && bus.find_addr_i >= sticky_first_q
                        && bus.find_addr_i <= sticky_last_q;
    assign bus.hit_o = fifo_hit | sticky_hit;
    assign bus.hit_first_o = fifo_first | (sticky_hit && bus.find_addr_i == sticky_first_q);
    assign bus.hit_sticky_o = sticky_hit;
    assign bus.count_o = count_q;
    assign bus.full_o = full_q;
    assign bus.overwrite_o = overwrite_q;
    assign bus.drop_o = drop_q;

    always_comb begin
        first_d = first_q;
        last_d = last_q;
        valid_d = valid_q;
        wr_ptr_d = wr_ptr_q;
        count_d = count_q;
        sticky_first_d = sticky_first_q;
        sticky_last_d = sticky_last_q;
        sticky_valid_d = sticky_valid_q;
        overwrite_d = 1'b0;
        drop_d = 1'b0;
        if (bus.clear_i) begin
            valid_d = '0;
            wr_ptr_d = '0;
            count_d = '0;
            sticky_valid_d = 1'b0;
        end else if (bus.wr_en_i) begin
            if (bus.wr_last_i < bus.wr_first_i) begin
                drop_d = 1'b1;
            end else if (bus.wr_big_i) begin
                sticky_first_d = bus.wr_first_i;
                sticky_last_d = bus.wr_last_i;
                sticky_valid_d = 1'b1;
            end else if (!dup) begin
                // wr_ptr always addresses the oldest entry once the FIFO is full
                first_d[wr_ptr_q] = bus.wr_first_i;
                last_d[wr_ptr_q] = bus.wr_last_i;
                valid_d[wr_ptr_q] = 1'b1;
                wr_ptr_d = wr_ptr_q + 1'b1;
                count_d = (count_q == FULL_CNT) ? count_q : count_q + 1'b1;
                overwrite_d = count_q == FULL_CNT;
            end
        end
        full_d = count_d == FULL_CNT;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < DEPTH; i++) begin
                first_q[i] <= '0;
                last_q[i] <= '0;
            end
            valid_q <= '0;
            wr_ptr_q <= '0;
            count_q <= '0;
            full_q <= 1'b0;
            sticky_first_q <= '0;
            sticky_last_q <= '0;
            sticky_valid_q <= 1'b0;
            overwrite_q <= 1'b0;
            drop_q <= 1'b0;
        end else begin
            first_q <= first_d;
            last_q <= last_d;
            valid_q <= valid_d;
            wr_ptr_q <= wr_ptr_d;
            count_q <= count_d;
            full_q <= full_d;
            sticky_first_q <= sticky_first_d;
            sticky_last_q <= sticky_last_d;
            sticky_valid_q <= sticky_valid_d;
            overwrite_q <= overwrite_d;
            drop_q <= drop_d;
        end
    end
endmodule

// File: tb/tb_bof_interval_table.sv
// tb_bof_interval_table: directed and random checks of the interval table against a
// queue-based reference model (oldest-first list of ranges plus one sticky range).
module tb_bof_interval_table;
    localparam int AW = 32;
    localparam int DEPTH = 8;

    typedef struct packed {
        logic [AW-1:0] f;
        logic [AW-1:0] l;
    } iv_t;

    logic clk_i = 1'b0;
    logic rst_ni = 1'b0;
    int   total = 0;
    int   bad = 0;

    iv_t  m_q[$];
    iv_t  m_s;
    logic m_sv = 1'b0;
    logic exp_ov = 1'b0;
    logic exp_dr = 1'b0;

    bof_interval_table_if #(.AW(AW), .DEPTH(DEPTH)) bus ();
    bof_interval_table #(.AW(AW), .DEPTH(DEPTH)) dut (.clk_i(clk_i), .rst_ni(rst_ni), .bus(bus));

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [2:0] m_look(input logic [AW-1:0] a);
        logic h = 1'b0, fi = 1'b0, st = 1'b0;
        foreach (m_q[i]) if (a >= m_q[i].f && a <= m_q[i].l) begin
            h = 1'b1;
            if (a == m_q[i].f) fi = 1'b1;
        end
        if (m_sv && a >= m_s.f && a <= m_s.l) begin
            h = 1'b1;
            st = 1'b1;
            if (a == m_s.f) fi = 1'b1;
        end
        return {h, fi, st};
    endfunction

    function automatic void m_reset();
        m_q.delete();
        m_sv = 1'b0;
        exp_ov = 1'b0;
        exp_dr = 1'b0;
    endfunction

    function automatic void m_step(input logic we, clr, big, input logic [AW-1:0] f, l);
        logic dup = 1'b0;
        exp_ov = 1'b0;
        exp_dr = 1'b0;
        if (clr) begin
            m_q.delete();
            m_sv = 1'b0;
        end else if (we) begin
            foreach (m_q[i]) if (m_q[i].f == f && m_q[i].l == l) dup = 1'b1;
            if (l < f) exp_dr = 1'b1;
            else if (big) begin
                m_s = '{f: f, l: l};
                m_sv = 1'b1;
            end else if (!dup) begin
                if (m_q.size() == DEPTH) begin
                    void'(m_q.pop_front());
                    exp_ov = 1'b1;
                end
                m_q.push_back('{f: f, l: l});
            end
        end
    endfunction

    task automatic check_look(input string tag);
        logic [2:0] e = m_look(bus.find_addr_i);
        chk({tag, "_hit"}, 32'(bus.hit_o), 32'(e[2]));
        chk({tag, "_first"}, 32'(bus.hit_first_o), 32'(e[1]));
        chk({tag, "_sticky"}, 32'(bus.hit_sticky_o), 32'(e[0]));
    endtask

    task automatic look(input logic [AW-1:0] a);
        bus.find_addr_i = a;
        #1;
        check_look("look");
    endtask

    task automatic cycle(input logic we, clr, big, input logic [AW-1:0] f, l, fa);
        bus.wr_en_i = we;
        bus.clear_i = clr;
        bus.wr_big_i = big;
        bus.wr_first_i = f;
        bus.wr_last_i = l;
        bus.find_addr_i = fa;
        #1;
        check_look("cyc");
        @(posedge clk_i);
        #1;
        bus.wr_en_i = 1'b0;
        bus.clear_i = 1'b0;
        m_step(we, clr, big, f, l);
        chk("count", 32'(bus.count_o), 32'(m_q.size()));
        chk("full", 32'(bus.full_o), 32'(m_q.size() == DEPTH));
        chk("overwrite", 32'(bus.overwrite_o), 32'(exp_ov));
        chk("drop", 32'(bus.drop_o), 32'(exp_dr));
    endtask

    task automatic wr(input logic big, input logic [AW-1:0] f, l);
        cycle(1'b1, 1'b0, big, f, l, f);
    endtask

    initial begin
        bus.clear_i = 1'b0;
        bus.wr_en_i = 1'b0;
        bus.wr_big_i = 1'b0;
        bus.wr_first_i = '0;
        bus.wr_last_i = '0;
        bus.find_addr_i = 32'h1000;
        repeat (2) @(posedge clk_i);
        #2 rst_ni = 1'b1;
        @(posedge clk_i);
        #1;
        chk("rst_hit", 32'(bus.hit_o), 32'd0);
        chk("rst_count", 32'(bus.count_o), 32'd0);
        chk("rst_full", 32'(bus.full_o), 32'd0);
        chk("rst_pulses", {30'd0, bus.overwrite_o, bus.drop_o}, 32'd0);

        cycle(1'b1, 1'b0, 1'b0, 32'h1000, 32'h1010, 32'h1008);
        look(32'h1000);
        chk("t2_first", 32'(bus.hit_first_o), 32'd1);
        look(32'h1010);
        chk("t2_last", {30'd0, bus.hit_o, bus.hit_first_o}, 32'd2);
        look(32'h1011);
        chk("t2_past", 32'(bus.hit_o), 32'd0);

        cycle(1'b0, 1'b1, 1'b0, 0, 0, 0);
        for (int k = 1; k <= 9; k++) begin
            wr(1'b0, 32'(k * 256), 32'(k * 256 + 15));
            if (k == 8) chk("t3_full", 32'(bus.full_o), 32'd1);
        end
        chk("t3_ov", 32'(bus.overwrite_o), 32'd1);
        chk("t3_count", 32'(bus.count_o), 32'd8);
        look(32'h100);
        chk("t3_evicted", 32'(bus.hit_o), 32'd0);
        look(32'h900);
        chk("t3_newest", 32'(bus.hit_o), 32'd1);

        wr(1'b1, 32'h2000, 32'h2400);
        for (int k = 0; k < 8; k++) wr(1'b0, 32'(32'h3000 + k * 32), 32'(32'h3000 + k * 32 + 7));
        look(32'h2200);
        chk("t4_sticky", {30'd0, bus.hit_o, bus.hit_sticky_o}, 32'd3);

        wr(1'b0, 32'h50, 32'h40);
        chk("t5_drop", 32'(bus.drop_o), 32'd1);
        wr(1'b0, 32'h3020, 32'h3027);
        chk("t5_dup_count", 32'(bus.count_o), 32'd8);
        chk("t5_dup_ov", 32'(bus.overwrite_o), 32'd0);

        cycle(1'b1, 1'b1, 1'b0, 32'h50, 32'h40, 32'h3000);
        chk("t6_count", 32'(bus.count_o), 32'd0);
        chk("t6_drop", 32'(bus.drop_o), 32'd0);
        look(32'h2200);
        chk("t6_sticky_gone", 32'(bus.hit_o), 32'd0);

        wr(1'b0, 32'hFFFF_FFF0, 32'hFFFF_FFFF);
        look(32'hFFFF_FFFF);
        chk("top_edge", {30'd0, bus.hit_o, bus.hit_first_o}, 32'd2);
        look(32'h0);

        for (int n = 0; n < 400; n++) begin
            logic [AW-1:0] f = AW'($urandom_range(0, 15) * 16);
            logic [AW-1:0] l = ($urandom_range(0, 7) == 0 && f != 0) ? f - 1 : f + AW'($urandom_range(0, 40));
            cycle($urandom_range(0, 2) != 0, $urandom_range(0, 40) == 0, $urandom_range(0, 7) == 0,
                  f, l, AW'($urandom_range(0, 300)));
            look(AW'($urandom_range(0, 300)));
        end

        wr(1'b0, 32'h7000, 32'h7010);
        #2 rst_ni = 1'b0;
        #1;
        m_reset();
        chk("arst_count", 32'(bus.count_o), 32'd0);
        look(32'h7000);
        chk("arst_hit", 32'(bus.hit_o), 32'd0);
        @(negedge clk_i);
        rst_ni = 1'b1;
        @(posedge clk_i);
        #1;
        cycle(1'b0, 1'b0, 1'b0, 0, 0, 32'h7008);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
